dmem_uart_dump: RTL and testbench

Debug-port initiator that reads a range of data-memory words through the core's `debug_address`/`debug_data` port and streams them out as 8N1 UART bytes. It sits outside the `mips` top and drives the core's debug address input, consuming the word returned on the debug data output. It gives the board a memory dump path without halting or modifying the core.

---
 rtl/dmem_uart_dump.sv | 173 +++++++++++++++++
 tb/tb_dmem_uart_dump.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_dump.sv
// Debug-port memory dump: reads data-memory words through the core debug
// port and streams them MSB-byte first as 8N1 UART frames.
module dmem_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [15:0] word_count,
  output logic [31:0] debug_address,
  input  logic [31:0] debug_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [15:0] remaining;
  logic [31:0] shreg;
  logic        tx_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  logic        bit_end;
  logic        in_frame;
  logic        last_byte;
  logic        more_words;
  logic        wc_zero;
  logic [7:0]  cur_byte;

  assign bit_end    = (baud_cnt == BAUD_MAX);
  assign in_frame   = (state == S_START) || (state == S_DATA) ||
                      (state == S_STOP);
  assign last_byte  = (byte_idx == 2'd3);
  assign more_words = (remaining > 16'd1);
  assign wc_zero    = (word_count == 16'd0);
  assign cur_byte   = shreg[31:24];

  // State and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start && !wc_zero)
          state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_START;
      S_START: begin
        if (bit_end)
          state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7)
          state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!last_byte)
            state_nxt = S_START;
          else if (more_words)
            state_nxt = S_FETCH;
          else
            state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_nxt   = tx;
    busy_nxt = busy;
    done_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy_nxt = !wc_zero;
          done_nxt = wc_zero;
        end
      end
      S_FETCH: tx_nxt = 1'b0;
      S_START: begin
        if (bit_end)
          tx_nxt = cur_byte[0];
      end
      S_DATA: begin
        if (bit_end)
          tx_nxt = (bit_idx == 3'd7) ? 1'b1
                   : cur_byte[bit_idx + 3'd1];
      end
      S_STOP: begin
        if (bit_end) begin
          if (!last_byte) begin
            tx_nxt = 1'b0;
          end else if (!more_words) begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath: address, word/byte/bit counters, shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_address <= 32'h0;
      remaining     <= 16'h0;
      shreg         <= 32'h0;
      baud_cnt      <= 16'h0;
      bit_idx       <= 3'd0;
      byte_idx      <= 2'd0;
    end else begin
      if (state == S_IDLE && start && !wc_zero) begin
        debug_address <= {start_addr[31:2], 2'b00};
        remaining     <= word_count;
      end
      if (state == S_FETCH) begin
        shreg    <= debug_data;
        byte_idx <= 2'd0;
        bit_idx  <= 3'd0;
        baud_cnt <= 16'h0;
      end
      if (in_frame)
        baud_cnt <= bit_end ? 16'h0 : baud_cnt + 16'd1;
      if (state == S_DATA && bit_end)
        bit_idx <= bit_idx + 3'd1;
      if (state == S_STOP && bit_end) begin
        if (!last_byte) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= {shreg[23:0], 8'h00};
        end else if (more_words) begin
          remaining     <= remaining - 16'd1;
          debug_address <= debug_address + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_uart_dump.sv
// Bench for dmem_uart_dump: table of dump requests plus reset, zero-length,
// busy/wrap and mid-frame reset sequences, with a UART frame decoder.
module tb_dmem_uart_dump;

  localparam int C = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] word_count;
  logic [31:0] debug_address;
  logic [31:0] debug_data;
  logic        tx;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  logic [7:0]  rx_q[$];
  logic [31:0] addr_q[$];

  dmem_uart_dump #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .word_count   (word_count),
    .debug_address(debug_address),
    .debug_data   (debug_data),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'hA53C_0F81;
      32'h0000_0020: return 32'h1122_3344;
      32'h0000_0024: return 32'hDEAD_BEEF;
      32'h0000_0028: return 32'h00FF_7E01;
      32'hFFFF_FFFC: return 32'hCAFE_F00D;
      32'h0000_0000: return 32'h8001_55AA;
      default:       return a ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  always_comb debug_data = mem_rd(debug_address);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // UART decoder: samples mid-bit on falling clock edges
  logic       mon_prev;
  logic       mon_ok;
  logic [7:0] mon_b;
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && mon_prev && !tx) begin
        mon_ok = 1'b1;
        @(negedge clk);
        if (!rst) mon_ok = 1'b0;
        else chk("start_bit", {31'b0, tx}, 32'h0);
        for (int k = 0; k < 8; k++) begin
          repeat (C) @(negedge clk);
          if (!rst) mon_ok = 1'b0;
          mon_b[k] = tx;
        end
        repeat (C) @(negedge clk);
        if (!rst) mon_ok = 1'b0;
        if (mon_ok) begin
          chk("stop_bit", {31'b0, tx}, 32'h1);
          rx_q.push_back(mon_b);
        end
      end
      mon_prev = tx;
    end
  end

  always @(negedge clk) begin
    if (rst && busy &&
        (addr_q.size() == 0 || addr_q[$] != debug_address))
      addr_q.push_back(debug_address);
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wc;
    logic [31:0] a0;
    int          cyc;
    int          nbytes;
    int          inject;
  } vec_t;

  vec_t vecs[5];

  task automatic run_dump(input vec_t v, input string nm);
    int          cycles;
    int          busy_low;
    logic        seen;
    logic [31:0] wd;
    logic [7:0]  eb;
    rx_q.delete();
    addr_q.delete();
    @(negedge clk);
    start      = 1'b1;
    start_addr = v.addr;
    word_count = v.wc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_e0"}, {31'b0, busy}, 32'h1);
    chk({nm, "_addr_e0"}, debug_address, v.a0);
    cycles   = 0;
    busy_low = 0;
    seen     = 1'b0;
    while (cycles < v.cyc + 50) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == v.inject) begin
        start      = 1'b1;
        start_addr = 32'h0000_0040;
        word_count = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_low++;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, {31'b0, seen}, 32'h1);
    chk({nm, "_busy_cycles"}, cycles, v.cyc);
    chk({nm, "_busy_gaps"}, busy_low, 0);
    chk({nm, "_busy_at_done"}, {31'b0, busy}, 32'h0);
    @(posedge clk);
    #1;
    chk({nm, "_done_width"}, {31'b0, done}, 32'h0);
    busy_low = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (busy) busy_low++;
    end
    chk({nm, "_idle_after"}, busy_low, 0);
    chk({nm, "_addr_hold"}, debug_address,
        v.a0 + 32'(4 * (int'(v.wc) - 1)));
    chk({nm, "_nbytes"}, rx_q.size(), v.nbytes);
    chk({nm, "_naddr"}, addr_q.size(), int'(v.wc));
    for (int i = 0; i < addr_q.size() && i < int'(v.wc); i++)
      chk({nm, "_addr_seq"}, addr_q[i], v.a0 + 32'(4 * i));
    for (int i = 0; i < rx_q.size() && i < v.nbytes; i++) begin
      wd = mem_rd(v.a0 + 32'(4 * (i / 4)));
      eb = 8'(wd >> (24 - 8 * (i % 4)));
      chk({nm, "_byte"}, {24'b0, rx_q[i]}, {24'b0, eb});
    end
  endtask

  logic [31:0] addr_before;
  int          done_cnt;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    start      = 1'b1;
    start_addr = 32'h0000_0010;
    word_count = 16'd1;

    vecs[0] = '{32'h0000_0010, 16'd1, 32'h0000_0010, 161, 4, -1};
    vecs[1] = '{32'h0000_0023, 16'd3, 32'h0000_0020, 483, 12, -1};
    vecs[2] = '{32'h0000_0101, 16'd2, 32'h0000_0100, 322, 8, -1};
    vecs[3] = '{32'h0000_0007, 16'd1, 32'h0000_0004, 161, 4, -1};
    vecs[4] = '{32'hFFFF_FFFC, 16'd2, 32'hFFFF_FFFC, 322, 8, 100};

    // Reset held with start asserted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'b0, tx}, 32'h1);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_addr", debug_address, 32'h0);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_dump(vecs[i], $sformatf("vec%0d", i));

    // Zero-length request
    rx_q.delete();
    addr_before = debug_address;
    @(negedge clk);
    start      = 1'b1;
    start_addr = 32'h0000_0500;
    word_count = 16'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_done", {31'b0, done}, 32'h1);
    chk("zero_busy", {31'b0, busy}, 32'h0);
    chk("zero_tx", {31'b0, tx}, 32'h1);
    chk("zero_addr", debug_address, addr_before);
    @(posedge clk);
    #1;
    chk("zero_done_width", {31'b0, done}, 32'h0);
    repeat (C * 12) @(posedge clk);
    #1;
    chk("zero_no_bytes", rx_q.size(), 0);

    // Busy start ignored, address wraps past 2^32
    run_dump(vecs[4], "wrap");

    // Reset during data bit 3 of byte 1
    rx_q.delete();
    @(negedge clk);
    start      = 1'b1;
    start_addr = 32'h0000_0010;
    word_count = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (58) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, tx}, 32'h1);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_done", {31'b0, done}, 32'h0);
    chk("mid_rst_addr", debug_address, 32'h0);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b1;
    repeat (C * 12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_nbytes", rx_q.size(), 1);
    if (rx_q.size() > 0)
      chk("mid_rst_byte0", {24'b0, rx_q[0]}, 32'h0000_00A5);
    run_dump(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
